// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter sharing one FIFO push port among NUM_REQ requesters.
// Packet mode: a requester that pushes a non-last word keeps the port until its
// last word, or until the owner has been idle for LOCK_TIMEOUT cycles.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_i, last_i, dat_i     per-requester request, end-of-packet, data (req 0 at LSBs)
//   gnt_o                    one-hot-or-zero grant
//   fifo_full_i              FIFO full, blocks all grants
//   fifo_push_o, fifo_dat_o  FIFO push strobe and data (0 with no grant)
//   locked_o, owner_o        lock state and current/last owner index
//   timeout_o                one-cycle pulse when the watchdog drops a lock
module fifo_push_arb #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_TIMEOUT = 16,
  parameter int LOG_NUM_REQ  = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] dat_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_dat_o,
  output logic                          locked_o,
  output logic [LOG_NUM_REQ-1:0]        owner_o,
  output logic                          timeout_o
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t                 state_q, state_d;
  logic [LOG_NUM_REQ-1:0] ptr_q, ptr_d;
  logic [LOG_NUM_REQ-1:0] owner_q, owner_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;

  logic                   found;
  logic [LOG_NUM_REQ-1:0] win;
  logic [LOG_NUM_REQ-1:0] idx;
  int                     sum;

  function automatic logic [LOG_NUM_REQ-1:0] inc(
    input logic [LOG_NUM_REQ-1:0] i
  );
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + LOG_NUM_REQ'(1);
  endfunction

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = LOG_NUM_REQ'(sum);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (!rst_i && !fifo_full_i) begin
      if (state_q == IDLE) begin
        if (found) gnt_o[win] = 1'b1;
      end else begin
        gnt_o[owner_q] = req_i[owner_q];
      end
    end
  end

  assign fifo_push_o = |(req_i & gnt_o);

  always_comb begin
    fifo_dat_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) fifo_dat_o = dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_push_o) begin
          ptr_d   = inc(win);
          owner_d = win;
          if (!last_i[win]) begin
            state_d = LOCK;
            cnt_d   = '0;
          end
        end
      end
      LOCK: begin
        // A full FIFO freezes everything, so back-pressure never ages the lock.
        if (!fifo_full_i) begin
          if (req_i[owner_q]) begin
            if (last_i[owner_q]) begin
              state_d = IDLE;
              ptr_d   = inc(owner_q);
            end else begin
              cnt_d = '0;
            end
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            state_d = IDLE;
            ptr_d   = inc(owner_q);
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign locked_o  = (state_q == LOCK);
  assign owner_o   = owner_q;
  assign timeout_o = tmo_q;

endmodule
